// File: rtl/playback_scheduler.sv
// Drum-machine sequencer core: tempo-driven step launches (PLAY), button-edge
// triggers (RAW), per-voice gate timing with one-clock restart gap, and sample mixing.
module playback_scheduler #(
  parameter int STEPS    = 8,
  parameter int VOICES   = 4,
  parameter int GATE_LEN = 4000,
  parameter int TEMPO_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode,
  input  logic [TEMPO_W-1:0]          tempo_lim,
  input  logic                        smpl_tick,
  input  logic [STEPS*VOICES-1:0]     pattern,
  input  logic [VOICES-1:0]           raw_trig,
  input  logic [VOICES*8-1:0]         voice_smpl,
  output logic [$clog2(STEPS)-1:0]    step_idx,
  output logic [STEPS-1:0]            step_onehot,
  output logic                        step_pulse,
  output logic [VOICES-1:0]           voice_en,
  output logic [7:0]                  mix_out
);

  localparam int SIW    = $clog2(STEPS);
  localparam int MIX_SH = $clog2(VOICES);
  localparam int SUMW   = 8 + MIX_SH;
  localparam int GCW    = (GATE_LEN > 1) ? $clog2(GATE_LEN) : 1;

  typedef enum logic [1:0] {
    MODE_EDIT = 2'd0,
    MODE_PLAY = 2'd1,
    MODE_RAW  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  mode_e              w_mode;
  logic               w_play;
  logic               w_raw;
  logic               w_launch;
  logic [SIW-1:0]     w_step_nxt;
  logic [VOICES-1:0]  w_trig;
  logic [SUMW-1:0]    w_sum;

  logic               r_prev_play;
  logic [VOICES-1:0]  r_raw_prev;
  logic [TEMPO_W-1:0] r_tcnt;
  logic [SIW-1:0]     r_step;
  logic [STEPS-1:0]   r_onehot;
  logic               r_pulse;
  logic [VOICES-1:0]  r_en;
  logic [VOICES-1:0]  r_pend;
  logic [GCW-1:0]     r_gcnt [VOICES];
  logic [7:0]         r_mix;

  assign w_mode = mode_e'(mode);
  assign w_play = (w_mode == MODE_PLAY);
  assign w_raw  = (w_mode == MODE_RAW);

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    w_launch   = 1'b0;
    w_step_nxt = r_step;
    w_trig     = '0;
    w_sum      = '0;
    if (w_play) begin
      if (!r_prev_play) begin
        w_launch   = 1'b1;
        w_step_nxt = '0;
      end else if (r_tcnt >= tempo_lim) begin
        w_launch   = 1'b1;
        w_step_nxt = (r_step == SIW'(STEPS-1)) ? '0 : r_step + 1'b1;
      end
    end
    if (w_launch)
      w_trig = pattern[w_step_nxt*VOICES +: VOICES];
    else if (w_raw)
      w_trig = raw_trig & ~r_raw_prev;
    for (int v = 0; v < VOICES; v++)
      if (r_en[v]) w_sum = w_sum + SUMW'(voice_smpl[v*8 +: 8]);
  end

  // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev_play <= 1'b0;
      r_raw_prev  <= '0;
      r_tcnt      <= '0;
      r_step      <= '0;
      r_onehot    <= STEPS'(1);
      r_pulse     <= 1'b0;
      r_en        <= '0;
      r_pend      <= '0;
      r_mix       <= '0;
      // NOTE: the gate counters are a handful of flops, not a RAM, so resetting them is cheap and safe.
      for (int v = 0; v < VOICES; v++) r_gcnt[v] <= '0;
    end else begin
      r_prev_play <= w_play;
      r_raw_prev  <= raw_trig;
      r_pulse     <= w_launch;
      if (w_launch) begin
        r_step   <= w_step_nxt;
        r_onehot <= STEPS'(1) << w_step_nxt;
      end
      if (w_play) r_tcnt <= w_launch ? '0 : r_tcnt + 1'b1;
      else        r_tcnt <= '0;
      if (smpl_tick) r_mix <= w_sum[MIX_SH +: 8];

      // Retrigger of a sounding voice forces one low clock so the sample restarts.
      for (int v = 0; v < VOICES; v++) begin
        if (!w_play && !w_raw) begin
          r_en[v]   <= 1'b0;
          r_pend[v] <= 1'b0;
          r_gcnt[v] <= '0;
        end else if (r_pend[v]) begin
          r_en[v]   <= 1'b1;
          r_pend[v] <= 1'b0;
          r_gcnt[v] <= '0;
        end else if (w_trig[v]) begin
          if (r_en[v]) begin
            r_en[v]   <= 1'b0;
            r_pend[v] <= 1'b1;
          end else begin
            r_en[v]   <= 1'b1;
            r_gcnt[v] <= '0;
          end
        end else if (r_en[v] && smpl_tick) begin
          if (r_gcnt[v] == GCW'(GATE_LEN-1)) begin
            r_en[v]   <= 1'b0;
            r_gcnt[v] <= '0;
          end else begin
            r_gcnt[v] <= r_gcnt[v] + 1'b1;
          end
        end
      end
    end
  end

  assign step_idx    = r_step;
  assign step_onehot = r_onehot;
  assign step_pulse  = r_pulse;
  assign voice_en    = r_en;
  assign mix_out     = r_mix;

endmodule

// File: tb/tb_playback_scheduler.sv
// Self-checking bench for playback_scheduler: directed scenarios plus randomized
// mode/tempo/pattern traffic, all compared against a time-based reference model.
module tb_playback_scheduler;

  localparam int GL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [15:0] tempo_lim;
  logic        smpl_tick;
  logic [31:0] pattern;
  logic [3:0]  raw_trig;
  logic [31:0] voice_smpl;
  logic [2:0]  step_idx;
  logic [7:0]  step_onehot;
  logic        step_pulse;
  logic [3:0]  voice_en;
  logic [7:0]  mix_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: time of last launch, ticks left per voice, restart gaps.
  int       cyc = 0;
  int       m_last = 0;
  int       m_step = 0;
  bit       m_pulse = 0;
  int       m_left [4] = '{default: 0};
  bit [3:0] m_gap = '0;
  int       m_mix = 0;
  bit       m_prev_play = 0;
  bit [3:0] m_raw_prev = '0;

  playback_scheduler #(.STEPS(8), .VOICES(4), .GATE_LEN(GL), .TEMPO_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .tempo_lim   (tempo_lim),
    .smpl_tick   (smpl_tick),
    .pattern     (pattern),
    .raw_trig    (raw_trig),
    .voice_smpl  (voice_smpl),
    .step_idx    (step_idx),
    .step_onehot (step_onehot),
    .step_pulse  (step_pulse),
    .voice_en    (voice_en),
    .mix_out     (mix_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_en();
    logic [3:0] e;
    for (int v = 0; v < 4; v++) e[v] = (m_left[v] > 0);
    return e;
  endfunction

  // Advance the model by one clock edge using the inputs present before the edge.
  task automatic model_edge();
    bit       play = (mode == 2'd1);
    bit       raw  = (mode == 2'd2);
    bit       launch = 0;
    logic [3:0] trig = '0;
    int       sum = 0;
    logic [31:0] pat = pattern;
    if (!rst) begin
      m_step = 0; m_pulse = 0; m_gap = '0; m_mix = 0;
      m_prev_play = 0; m_raw_prev = '0; m_last = cyc;
      for (int v = 0; v < 4; v++) m_left[v] = 0;
      cyc++;
      return;
    end
    if (smpl_tick) begin
      for (int v = 0; v < 4; v++) if (m_left[v] > 0) sum += int'(voice_smpl[v*8 +: 8]);
      m_mix = sum / 4;
    end
    if (play) begin
      if (!m_prev_play) begin
        launch = 1; m_step = 0; m_last = cyc;
      end else if (cyc - m_last > int'(tempo_lim)) begin
        launch = 1; m_step = (m_step + 1) % 8; m_last = cyc;
      end
    end
    m_pulse = launch;
    if (launch) trig = pat[m_step*4 +: 4];
    else if (raw) trig = raw_trig & ~m_raw_prev;
    for (int v = 0; v < 4; v++) begin
      if (!play && !raw) begin
        m_left[v] = 0; m_gap[v] = 0;
      end else if (m_gap[v]) begin
        m_gap[v] = 0; m_left[v] = GL;
      end else if (trig[v]) begin
        if (m_left[v] > 0) begin m_left[v] = 0; m_gap[v] = 1; end
        else m_left[v] = GL;
      end else if (m_left[v] > 0 && smpl_tick) begin
        m_left[v]--;
      end
    end
    m_prev_play = play;
    m_raw_prev  = raw_trig;
    cyc++;
  endtask

  task automatic cyc_step();
    model_edge();
    @(posedge clk);
    #1;
    check("step_idx",    step_idx,    m_step);
    check("step_onehot", step_onehot, 32'(8'(1) << m_step));
    check("step_pulse",  step_pulse,  m_pulse);
    check("voice_en",    voice_en,    model_en());
    check("mix_out",     mix_out,     m_mix);
  endtask

  initial begin
    int cnt;
    rst = 1'b0; mode = 2'd0; tempo_lim = '0; smpl_tick = 1'b0;
    pattern = '0; raw_trig = '0; voice_smpl = '0;

    // Reset, then EDIT with noisy inputs: nothing may fire.
    repeat (2) cyc_step();
    check("reset_onehot", step_onehot, 32'h1);
    check("reset_en", voice_en, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      pattern = $urandom; raw_trig = 4'($urandom); smpl_tick = 1'($urandom);
      voice_smpl = $urandom;
      cyc_step();
    end
    check("edit_quiet", voice_en, 32'h0);

    // PLAY, tempo_lim=9, only step 0 / voice 0 in the pattern.
    raw_trig = '0; pattern = 32'h1; tempo_lim = 16'd9; mode = 2'd1;
    for (int i = 0; i < 95; i++) begin
      smpl_tick = (i % 2 == 0);
      cyc_step();
      if (i == 0) begin
        check("first_play_pulse", step_pulse, 32'h1);
        check("first_play_en0", voice_en, 32'h1);
      end
    end

    // Single trigger on voice 1: exactly GL ticks while enabled.
    mode = 2'd0; smpl_tick = 1'b0; cyc_step();
    pattern = 32'h2; tempo_lim = 16'd200; mode = 2'd1; cnt = 0;
    for (int i = 0; i < 30; i++) begin
      smpl_tick = (i % 2 == 1);
      if (smpl_tick && voice_en[1]) cnt++;
      cyc_step();
    end
    check("gate_ticks", cnt, GL);
    check("gate_done", voice_en[1], 1'b0);

    // RAW retrigger: one-clock low gap on voice 2, held button does not retrigger.
    mode = 2'd0; smpl_tick = 1'b0; cyc_step();
    mode = 2'd2; raw_trig = 4'h0; cyc_step();
    raw_trig = 4'h4; cyc_step();
    check("raw_on", voice_en[2], 1'b1);
    raw_trig = 4'h0; cyc_step(); cyc_step();
    raw_trig = 4'h4; cyc_step();
    check("raw_gap", voice_en[2], 1'b0);
    cyc_step();
    check("raw_restart", voice_en[2], 1'b1);
    cyc_step();
    check("raw_held", voice_en[2], 1'b1);

    // Mix of voices 0 and 1.
    raw_trig = 4'h0; mode = 2'd0; cyc_step();
    mode = 2'd2; raw_trig = 4'h3; cyc_step();
    voice_smpl = 32'h0000_01FF; smpl_tick = 1'b1; cyc_step();
    check("mix_ff_01", mix_out, 32'h40);
    smpl_tick = 1'b0; mode = 2'd0; cyc_step();
    smpl_tick = 1'b1; cyc_step();
    check("mix_idle", mix_out, 32'h0);

    // Mode exit from PLAY with voices sounding, then reset mid-play.
    smpl_tick = 1'b0; pattern = 32'hFFFF_FFFF; tempo_lim = 16'd3; mode = 2'd1;
    repeat (6) cyc_step();
    mode = 2'd0; cyc_step();
    check("exit_en", voice_en, 32'h0);
    mode = 2'd1; repeat (7) cyc_step();
    rst = 1'b0; cyc_step();
    check("midplay_rst_step", step_idx, 32'h0);
    check("midplay_rst_en", voice_en, 32'h0);
    rst = 1'b1;

    // tempo_lim=0: a launch on every clock.
    tempo_lim = 16'd0; pattern = $urandom; repeat (12) cyc_step();

    // Randomized segments with live tempo changes and rare resets.
    for (int seg = 0; seg < 30; seg++) begin
      int len;
      mode = 2'($urandom); tempo_lim = 16'($urandom_range(12)); pattern = $urandom;
      len = $urandom_range(20, 150);
      for (int i = 0; i < len; i++) begin
        smpl_tick  = ($urandom_range(2) == 0);
        voice_smpl = $urandom;
        if ($urandom_range(3) == 0) raw_trig = 4'($urandom);
        if ($urandom_range(40) == 0) tempo_lim = 16'($urandom_range(12));
        rst = ($urandom_range(400) != 0);
        cyc_step();
      end
      rst = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
